// File: rtl/descriptor_fetcher.sv
// Walks a linked chain of 4-word DMA descriptors in on-chip memory, presents
// each owned descriptor downstream and writes completion status back.
module descriptor_fetcher #(
  parameter int ADDR_WIDTH = 9,
  parameter int DESC_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic                  stop,
  output logic                  busy,
  output logic                  halted_unowned,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [3:0]            mem_byteenable,
  output logic [31:0]           mem_writedata,
  output logic                  mem_clken,
  input  logic [31:0]           mem_readdata,
  output logic                  desc_valid,
  input  logic                  desc_ready,
  output logic [31:0]           desc_buf_addr,
  output logic [15:0]           desc_length,
  output logic                  desc_eop,
  input  logic                  cpl_valid,
  input  logic [6:0]            cpl_status
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_CHECK     = 3'd2,
    S_PRESENT   = 3'd3,
    S_WAIT_CPL  = 3'd4,
    S_WRITEBACK = 3'd5,
    S_NEXT      = 3'd6
  } state_t;

  localparam logic [2:0]            LAST_ISSUE = 3'(DESC_WORDS - 1);
  localparam logic [2:0]            LAST_CAP   = 3'(DESC_WORDS);
  localparam logic [ADDR_WIDTH-1:0] STATUS_OFS = ADDR_WIDTH'(DESC_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE_A      = ADDR_WIDTH'(1);
  localparam logic [3:0]            BE_ALL     = 4'hF;
  localparam logic [3:0]            BE_STATUS  = 4'b1000;

  // Status write-back word: clears owned_by_hw, all non-status bits masked by byteenable.
  function automatic logic [31:0] wb_word(input logic [6:0] st);
    return {1'b0, st, 24'h000000};
  endfunction

  state_t                state_r, state_nxt_s;
  logic [2:0]            fcnt_r, fcnt_nxt_s;
  logic [ADDR_WIDTH-1:0] cur_r, cur_nxt_s;
  logic [31:0]           w0_r;
  logic [ADDR_WIDTH-1:0] w1_r;
  logic [15:0]           w2_r;
  logic                  owned_r, eop_r;
  logic                  busy_r, busy_nxt_s;
  logic                  halt_r, halt_nxt_s;
  logic                  err_r, err_nxt_s;
  logic                  dvalid_r, dvalid_nxt_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
  logic                  cs_r, cs_nxt_s;
  logic                  we_r, we_nxt_s;
  logic [3:0]            be_r, be_nxt_s;
  logic [31:0]           wd_r, wd_nxt_s;
  logic                  go_fetch_s, go_wb_s;
  logic [ADDR_WIDTH-1:0] fetch_addr_s;

  // Next-state, flag and memory-command decode.
  always_comb begin
    state_nxt_s  = state_r;
    fcnt_nxt_s   = fcnt_r;
    cur_nxt_s    = cur_r;
    busy_nxt_s   = busy_r;
    halt_nxt_s   = halt_r;
    err_nxt_s    = err_r;
    dvalid_nxt_s = 1'b0;
    go_fetch_s   = 1'b0;
    go_wb_s      = 1'b0;
    fetch_addr_s = cur_r;
    addr_nxt_s   = {ADDR_WIDTH{1'b0}};
    cs_nxt_s     = 1'b0;
    we_nxt_s     = 1'b0;
    be_nxt_s     = 4'h0;
    wd_nxt_s     = 32'h0000_0000;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          halt_nxt_s = 1'b0;
          if (base_addr[1:0] != 2'b00) begin
            err_nxt_s = 1'b1;
          end else begin
            err_nxt_s    = 1'b0;
            busy_nxt_s   = 1'b1;
            cur_nxt_s    = base_addr;
            fetch_addr_s = base_addr;
            go_fetch_s   = 1'b1;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_FETCH: begin
        if (fcnt_r == LAST_CAP) begin
          state_nxt_s = S_CHECK;
          fcnt_nxt_s  = 3'd0;
        end else begin
          fcnt_nxt_s  = fcnt_r + 3'd1;
        end
      end
      S_CHECK: begin
        if (!owned_r) begin
          halt_nxt_s  = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = S_IDLE;
        end else begin
          dvalid_nxt_s = 1'b1;
          state_nxt_s  = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (desc_ready) begin
          // completion may coincide with the handshake; go straight to write-back
          if (cpl_valid) begin
            go_wb_s = 1'b1;
          end else begin
            state_nxt_s = S_WAIT_CPL;
          end
        end else begin
          dvalid_nxt_s = 1'b1;
        end
      end
      S_WAIT_CPL: begin
        if (cpl_valid) begin
          go_wb_s = 1'b1;
        end else begin
          state_nxt_s = S_WAIT_CPL;
        end
      end
      S_WRITEBACK: begin
        state_nxt_s = S_NEXT;
      end
      S_NEXT: begin
        if (stop) begin
          busy_nxt_s  = 1'b0;
          state_nxt_s = S_IDLE;
        end else if (w1_r[1:0] != 2'b00) begin
          err_nxt_s   = 1'b1;
          busy_nxt_s  = 1'b0;
          state_nxt_s = S_IDLE;
        end else begin
          cur_nxt_s    = w1_r;
          fetch_addr_s = w1_r;
          go_fetch_s   = 1'b1;
        end
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = S_IDLE;
      end
    endcase

    if (go_fetch_s) begin
      state_nxt_s = S_FETCH;
      fcnt_nxt_s  = 3'd0;
      addr_nxt_s  = fetch_addr_s;
      cs_nxt_s    = 1'b1;
      be_nxt_s    = BE_ALL;
    end else if (go_wb_s) begin
      state_nxt_s = S_WRITEBACK;
      addr_nxt_s  = cur_r + STATUS_OFS;
      cs_nxt_s    = 1'b1;
      we_nxt_s    = 1'b1;
      be_nxt_s    = BE_STATUS;
      wd_nxt_s    = wb_word(cpl_status);
    end else if ((state_r == S_FETCH) && (fcnt_r < LAST_ISSUE)) begin
      addr_nxt_s  = cur_r + ADDR_WIDTH'(fcnt_r) + ONE_A;
      cs_nxt_s    = 1'b1;
      be_nxt_s    = BE_ALL;
    end else begin
      cs_nxt_s    = 1'b0;
    end
  end

  // State, flags and registered memory / handshake outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= S_IDLE;
      fcnt_r   <= 3'd0;
      cur_r    <= {ADDR_WIDTH{1'b0}};
      busy_r   <= 1'b0;
      halt_r   <= 1'b0;
      err_r    <= 1'b0;
      dvalid_r <= 1'b0;
      addr_r   <= {ADDR_WIDTH{1'b0}};
      cs_r     <= 1'b0;
      we_r     <= 1'b0;
      be_r     <= 4'h0;
      wd_r     <= 32'h0000_0000;
    end else begin
      state_r  <= state_nxt_s;
      fcnt_r   <= fcnt_nxt_s;
      cur_r    <= cur_nxt_s;
      busy_r   <= busy_nxt_s;
      halt_r   <= halt_nxt_s;
      err_r    <= err_nxt_s;
      dvalid_r <= dvalid_nxt_s;
      addr_r   <= addr_nxt_s;
      cs_r     <= cs_nxt_s;
      we_r     <= we_nxt_s;
      be_r     <= be_nxt_s;
      wd_r     <= wd_nxt_s;
    end
  end

  // Capture each descriptor word one cycle after its read address was issued.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w0_r    <= 32'h0000_0000;
      w1_r    <= {ADDR_WIDTH{1'b0}};
      w2_r    <= 16'h0000;
      owned_r <= 1'b0;
      eop_r   <= 1'b0;
    end else if (state_r == S_FETCH) begin
      case (fcnt_r)
        3'd1:    w0_r <= mem_readdata;
        3'd2:    w1_r <= mem_readdata[ADDR_WIDTH-1:0];
        3'd3:    w2_r <= mem_readdata[15:0];
        3'd4: begin
          owned_r <= mem_readdata[31];
          eop_r   <= mem_readdata[16];
        end
        default: w0_r <= w0_r;
      endcase
    end else begin
      w0_r <= w0_r;
    end
  end

  assign busy           = busy_r;
  assign halted_unowned = halt_r;
  assign error          = err_r;
  assign mem_address    = addr_r;
  assign mem_chipselect = cs_r;
  assign mem_write      = we_r;
  assign mem_byteenable = be_r;
  assign mem_writedata  = wd_r;
  assign mem_clken      = 1'b1;
  assign desc_valid     = dvalid_r;
  assign desc_buf_addr  = w0_r;
  assign desc_length    = w2_r;
  assign desc_eop       = eop_r;

endmodule

// File: tb/tb_descriptor_fetcher.sv
// Directed bench for descriptor_fetcher with a behavioural descriptor memory
// (registered address, unregistered q) and a passive bus monitor.
module tb_descriptor_fetcher;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [8:0]  base_addr;
  logic        stop;
  logic        busy, halted_unowned, error;
  logic [8:0]  mem_address;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;
  logic        desc_valid, desc_ready;
  logic [31:0] desc_buf_addr;
  logic [15:0] desc_length;
  logic        desc_eop;
  logic        cpl_valid;
  logic [6:0]  cpl_status;

  descriptor_fetcher dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr), .stop(stop),
    .busy(busy), .halted_unowned(halted_unowned), .error(error),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_buf_addr(desc_buf_addr), .desc_length(desc_length), .desc_eop(desc_eop),
    .cpl_valid(cpl_valid), .cpl_status(cpl_status)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Descriptor memory model; bench preloads through the ld_* port.
  logic [31:0] mem [0:511];
  logic [8:0]  addr_q;
  logic        ld_en;
  logic [8:0]  ld_addr;
  logic [31:0] ld_data;
  assign mem_readdata = mem[addr_q];

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_chipselect && mem_write) begin
      for (int b = 0; b < 4; b++)
        if (mem_byteenable[b]) mem[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
    end
    if (mem_chipselect) addr_q <= mem_address;
  end

  // Bus monitor: logs reads, writes, handshakes and descriptor stability.
  logic [8:0]  rd_q[$];
  logic [8:0]  wr_q[$];
  int          hs_cnt = 0;
  int          drop_cnt = 0;
  int          chg_cnt = 0;
  logic        pv_r = 1'b0;
  logic        pr_r = 1'b0;
  logic [48:0] pf_r = '0;

  always @(negedge clk) begin
    if (mem_chipselect && !mem_write) rd_q.push_back(mem_address);
    if (mem_chipselect && mem_write) wr_q.push_back(mem_address);
    if (desc_valid && desc_ready) hs_cnt <= hs_cnt + 1;
    if (pv_r && !pr_r) begin
      if (!desc_valid) drop_cnt <= drop_cnt + 1;
      else if ({desc_buf_addr, desc_length, desc_eop} != pf_r) chg_cnt <= chg_cnt + 1;
    end
    pv_r <= desc_valid;
    pr_r <= desc_ready;
    pf_r <= {desc_buf_addr, desc_length, desc_eop};
  end

  int ncmp = 0;
  int nfail = 0;
  int r0, w0, h0, d0, c0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic poke(input logic [8:0] a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick(1);
    ld_en = 1'b0;
  endtask

  task automatic poke_desc(input logic [8:0] a, input logic [31:0] d0w, input logic [31:0] d1w,
                           input logic [31:0] d2w, input logic [31:0] d3w);
    poke(a, d0w);
    poke(a + 9'd1, d1w);
    poke(a + 9'd2, d2w);
    poke(a + 9'd3, d3w);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (desc_valid !== 1'b1 && n < 40) begin
      tick(1);
      n++;
    end
    check(tag, 32'(desc_valid), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 60) begin
      tick(1);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic kick(input logic [8:0] a);
    r0 = rd_q.size(); w0 = wr_q.size(); h0 = hs_cnt; d0 = drop_cnt; c0 = chg_cnt;
    base_addr = a; start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic complete(input logic [6:0] st);
    cpl_status = st; cpl_valid = 1'b1;
    tick(1);
    cpl_valid = 1'b0;
  endtask

  task automatic accept();
    desc_ready = 1'b1;
    tick(1);
    desc_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = 9'h000; stop = 1'b0;
    desc_ready = 1'b0; cpl_valid = 1'b0; cpl_status = 7'h00;
    ld_en = 1'b0; ld_addr = 9'h000; ld_data = 32'h0;
    tick(2);
    poke_desc(9'h010, 32'h2000_0000, 32'h0000_0010, 32'd64,  32'h8001_0000);
    poke_desc(9'h000, 32'h1000_0000, 32'h0000_0020, 32'd100, 32'h8000_0000);
    poke_desc(9'h020, 32'h1000_1000, 32'h0000_01FC, 32'd200, 32'h8001_0000);
    poke_desc(9'h1FC, 32'h0,         32'h0,         32'h0,   32'h0000_0000);
    poke_desc(9'h040, 32'hDEAD_BEE0, 32'h0000_0040, 32'h1234, 32'h8000_0000);
    poke_desc(9'h080, 32'h3000_0000, 32'h0000_0084, 32'd8,   32'h8001_0000);
    poke_desc(9'h084, 32'h3000_1000, 32'h0000_0080, 32'd8,   32'h8001_0000);
    poke_desc(9'h0A0, 32'h4000_0000, 32'h0000_0022, 32'd4,   32'h8000_0000);
    poke_desc(9'h0C0, 32'h5000_0000, 32'h0000_00C0, 32'd12,  32'h8000_0000);

    // reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cs", 32'(mem_chipselect), 32'd0);
    check("rst_clken", 32'(mem_clken), 32'd1);
    check("rst_addr", 32'(mem_address), 32'd0);
    check("rst_valid", 32'(desc_valid), 32'd0);
    check("rst_flags", 32'({halted_unowned, error}), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // misaligned base address
    kick(9'h101);
    check("mis_err", 32'(error), 32'd1);
    check("mis_busy", 32'(busy), 32'd0);
    tick(3);
    check("mis_reads", 32'(rd_q.size() - r0), 32'd0);

    // single self-looping descriptor
    kick(9'h010);
    check("t1_busy", 32'(busy), 32'd1);
    check("t1_err_clr", 32'(error), 32'd0);
    wait_valid("t1_valid");
    check("t1_buf", desc_buf_addr, 32'h2000_0000);
    check("t1_len", 32'(desc_length), 32'd64);
    check("t1_eop", 32'(desc_eop), 32'd1);
    accept();
    check("t1_valid_drop", 32'(desc_valid), 32'd0);
    tick(2);
    complete(7'h05);
    wait_idle("t1_idle");
    check("t1_halt", 32'(halted_unowned), 32'd1);
    check("t1_wbword", mem[9'h013], 32'h0501_0000);
    check("t1_hs", 32'(hs_cnt - h0), 32'd1);
    check("t1_wr", 32'(wr_q.size() - w0), 32'd1);
    check("t1_wraddr", 32'(wr_q[w0]), 32'h013);
    check("t1_reads", 32'(rd_q.size() - r0), 32'd8);
    check("t1_refetch", 32'(rd_q[r0+4]), 32'h010);

    // three-entry chain, last unowned
    kick(9'h000);
    check("t2_halt_clr", 32'(halted_unowned), 32'd0);
    wait_valid("t2a_valid");
    check("t2a_buf", desc_buf_addr, 32'h1000_0000);
    check("t2a_len", 32'(desc_length), 32'd100);
    accept();
    tick(1);
    complete(7'h11);
    wait_valid("t2b_valid");
    check("t2b_buf", desc_buf_addr, 32'h1000_1000);
    check("t2b_len", 32'(desc_length), 32'd200);
    accept();
    tick(1);
    complete(7'h22);
    wait_idle("t2_idle");
    check("t2_hs", 32'(hs_cnt - h0), 32'd2);
    check("t2_wr", 32'(wr_q.size() - w0), 32'd2);
    check("t2_wr0", 32'(wr_q[w0]), 32'h003);
    check("t2_wr1", 32'(wr_q[w0+1]), 32'h023);
    check("t2_mem3", mem[9'h003], 32'h1100_0000);
    check("t2_mem23", mem[9'h023], 32'h2201_0000);
    check("t2_halt", 32'(halted_unowned), 32'd1);
    check("t2_reads", 32'(rd_q.size() - r0), 32'd12);
    check("t2_rd_last", 32'(rd_q[r0+8]), 32'h1FC);

    // wrap at top of memory
    poke_desc(9'h1FC, 32'h6000_0000, 32'h0000_0000, 32'd32, 32'h8000_0000);
    kick(9'h1FC);
    wait_valid("t3_valid");
    desc_ready = 1'b1; cpl_valid = 1'b1; cpl_status = 7'h00;
    tick(1);
    desc_ready = 1'b0; cpl_valid = 1'b0;
    wait_idle("t3_idle");
    check("t3_reads", 32'(rd_q.size() - r0), 32'd8);
    check("t3_rd0", 32'(rd_q[r0]), 32'h1FC);
    check("t3_rd1", 32'(rd_q[r0+1]), 32'h1FD);
    check("t3_rd2", 32'(rd_q[r0+2]), 32'h1FE);
    check("t3_rd3", 32'(rd_q[r0+3]), 32'h1FF);
    check("t3_rd4", 32'(rd_q[r0+4]), 32'h000);
    check("t3_wr", 32'(wr_q[w0]), 32'h1FF);
    check("t3_halt", 32'(halted_unowned), 32'd1);

    // back-pressure with completion in the handshake cycle; start while busy
    kick(9'h040);
    wait_valid("t4_valid");
    base_addr = 9'h000; start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    check("t4_busy", 32'(busy), 32'd1);
    check("t4_held", 32'(desc_valid), 32'd1);
    check("t4_buf", desc_buf_addr, 32'hDEAD_BEE0);
    check("t4_len", 32'(desc_length), 32'h1234);
    check("t4_drop", 32'(drop_cnt - d0), 32'd0);
    check("t4_chg", 32'(chg_cnt - c0), 32'd0);
    desc_ready = 1'b1; cpl_valid = 1'b1; cpl_status = 7'h7F;
    tick(1);
    desc_ready = 1'b0; cpl_valid = 1'b0;
    check("t4_wb_we", 32'(mem_write), 32'd1);
    check("t4_wb_addr", 32'(mem_address), 32'h043);
    check("t4_wb_be", 32'(mem_byteenable), 32'h8);
    check("t4_wb_data", mem_writedata, 32'h7F00_0000);
    wait_idle("t4_idle");
    check("t4_mem", mem[9'h043], 32'h7F00_0000);
    check("t4_refetch", 32'(rd_q[r0+4]), 32'h040);

    // stop during PRESENT
    kick(9'h080);
    wait_valid("t5_valid");
    stop = 1'b1;
    accept();
    tick(1);
    complete(7'h01);
    wait_idle("t5_idle");
    stop = 1'b0;
    tick(3);
    check("t5_wr", 32'(wr_q.size() - w0), 32'd1);
    check("t5_wraddr", 32'(wr_q[w0]), 32'h083);
    check("t5_mem", mem[9'h083], 32'h0101_0000);
    check("t5_reads", 32'(rd_q.size() - r0), 32'd4);
    check("t5_flags", 32'({halted_unowned, error}), 32'd0);

    // misaligned next pointer
    kick(9'h0A0);
    wait_valid("t6_valid");
    desc_ready = 1'b1; cpl_valid = 1'b1; cpl_status = 7'h02;
    tick(1);
    desc_ready = 1'b0; cpl_valid = 1'b0;
    wait_idle("t6_idle");
    check("t6_err", 32'(error), 32'd1);
    check("t6_halt", 32'(halted_unowned), 32'd0);
    check("t6_wraddr", 32'(wr_q[w0]), 32'h0A3);
    check("t6_reads", 32'(rd_q.size() - r0), 32'd4);

    // reset while waiting for completion
    kick(9'h0C0);
    check("t7_err_clr", 32'(error), 32'd0);
    wait_valid("t7_valid");
    accept();
    tick(2);
    reset_n = 1'b0;
    #1;
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_mem", 32'({mem_chipselect, mem_write, mem_byteenable}), 32'd0);
    check("t7_addr_wd", 32'(mem_address) | mem_writedata, 32'd0);
    check("t7_clken", 32'(mem_clken), 32'd1);
    check("t7_desc", desc_buf_addr | 32'(desc_length) | 32'({desc_valid, desc_eop}), 32'd0);
    complete(7'h33);
    reset_n = 1'b1;
    tick(3);
    check("t7_nowr", 32'(wr_q.size() - w0), 32'd0);
    check("t7_memword", mem[9'h0C3], 32'h8000_0000);
    check("t7_idle", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
